// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug read-out engine for the single-cycle MIPS core's register file.
//   On a start request it walks register indices FIRST_REG..LAST_REG through
//   one RegFile read port and presents each value as a beat on a valid/ready
//   stream. The core keeps running, so each value is whatever the register
//   holds at the edge on which it is captured.
//
// Parameters
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG..31)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state immediately
//   start      level; begins a dump when seen in IDLE
//   abort      level; ends a dump when seen in FETCH or SEND
//   rf_addr    RegFile read address
//   rf_data    combinational RegFile read data for rf_addr
//   out_valid  stream beat valid
//   out_ready  downstream accepts the beat
//   out_data   captured register value
//   out_index  register index of out_data
//   out_last   beat carries index LAST_REG
//   busy       high while a dump is in progress (FETCH or SEND)
//   done       one-cycle pulse after the final beat is accepted
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  idx_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic [4:0]  out_index_q;
  logic        out_last_q;
  logic        busy_q;
  logic        done_q;

  // idx_q sits at FIRST_IDX whenever the engine is idle, so the read
  // address can be driven straight from it in every state.
  assign rf_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_IDX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start seen in the done cycle launches the next dump directly.
          if (start) begin
            state_q <= FETCH;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b1;
          end
        end

        FETCH: begin
          if (abort) begin
            state_q <= IDLE;
            idx_q   <= FIRST_IDX;
            busy_q  <= 1'b0;
          end else begin
            out_data_q  <= rf_data;
            out_index_q <= idx_q;
            out_last_q  <= (idx_q == LAST_IDX);
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end

        SEND: begin
          // Abort wins over a simultaneous handshake: the beat is dropped.
          if (abort) begin
            state_q     <= IDLE;
            idx_q       <= FIRST_IDX;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              idx_q   <= FIRST_IDX;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // idx_q stops at LAST_IDX, so this increment never wraps.
              idx_q   <= idx_q + 5'd1;
              state_q <= FETCH;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          idx_q       <= FIRST_IDX;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, out_ready;
  logic [4:0]  rf_addr, out_index;
  logic [31:0] rf_data, out_data;
  logic        out_valid, out_last, busy, done;

  logic        start1, abort1, ready1;
  logic [4:0]  rf_addr1, out_index1;
  logic [31:0] rf_data1, out_data1;
  logic        out_valid1, out_last1, busy1, done1;

  // Behavioural register file: combinational read, reg 0 kept at zero.
  logic [31:0] regs [32];
  assign rf_data  = regs[rf_addr];
  assign rf_data1 = regs[rf_addr1];

  regfile_dump u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) u_one (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .rf_addr(rf_addr1), .rf_data(rf_data1),
    .out_valid(out_valid1), .out_ready(ready1), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;
  int edge_no = 0;
  int done_cnt = 0;

  // Scoreboard of accepted beats
  int          got_idx  [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          got_edge [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    got_idx.delete();
    got_data.delete();
    got_last.delete();
    got_edge.delete();
    done_cnt = 0;
  endtask

  // One clock: a beat is accepted when valid & ready at the edge, unless
  // abort (or reset) takes precedence.
  task automatic tick();
    logic        hs;
    logic [31:0] d;
    logic [4:0]  ix;
    logic        l;
    hs = out_valid && out_ready && !abort && !reset;
    d  = out_data;
    ix = out_index;
    l  = out_last;
    @(posedge clk);
    edge_no++;
    #1;
    if (hs) begin
      got_idx.push_back(int'(ix));
      got_data.push_back(d);
      got_last.push_back(l);
      got_edge.push_back(edge_no);
    end
    if (done) done_cnt++;
    chk("done_excl_valid", 32'(done & out_valid), 32'd0);
  endtask

  task automatic wait_beat(input string tag, input int idx, input int budget);
    int n;
    n = 0;
    while (!(out_valid && int'(out_index) == idx) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 32'(out_valid && int'(out_index) == idx), 32'd1);
  endtask

  task automatic run_to_done(input string tag, input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  // Expected stream: indices first..last, each carrying the register value.
  task automatic check_beats(input string tag, input int first, input int last);
    chk({tag, "_count"}, 32'(got_idx.size()), 32'(last - first + 1));
    for (int i = 0; i < got_idx.size() && i <= last - first; i++) begin
      chk({tag, "_idx"},  32'(got_idx[i]), 32'(first + i));
      chk({tag, "_data"}, got_data[i], regs[first + i]);
      chk({tag, "_last"}, 32'(got_last[i]), 32'(first + i == last));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, a, done_edge;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    regs[0] = 32'h0;
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_addr",   32'(rf_addr),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_rf_addr1",  32'(rf_addr1),  32'd5);
    reset = 1'b0;
    tick(); tick();
    chk("idle_busy",  32'(busy),      32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Full dump with ready held high, latency checks
    clear_sb();
    start = 1'b1;
    tick();
    k = edge_no;
    start = 1'b0;
    chk("full_fetch_busy",  32'(busy),      32'd1);
    chk("full_fetch_valid", 32'(out_valid), 32'd0);
    chk("full_fetch_addr",  32'(rf_addr),   32'd0);
    tick();
    chk("full_first_valid", 32'(out_valid), 32'd1);
    chk("full_first_index", 32'(out_index), 32'd0);
    chk("full_first_data",  out_data,       32'd0);
    done_edge = -1;
    while (edge_no < k + 70) begin
      tick();
      if (done) done_edge = edge_no;
      chk("full_busy", 32'(busy), 32'(edge_no <= k + 63));
    end
    check_beats("full", 0, 31);
    chk("full_done_cnt",  32'(done_cnt),  32'd1);
    chk("full_done_edge", 32'(done_edge), 32'(k + 64));
    for (int n = 0; n < got_edge.size(); n++)
      chk("full_beat_edge", 32'(got_edge[n]), 32'(k + 2 + 2 * n));

    // Backpressure on beat 3
    clear_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beat("bp", 3, 50);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  out_data,       32'h1000_0003);
      chk("bp_index", 32'(out_index), 32'd3);
      chk("bp_addr",  32'(rf_addr),   32'd3);
    end
    out_ready = 1'b1;
    tick();
    a = edge_no;
    chk("bp_after_accept_valid", 32'(out_valid), 32'd0);
    run_to_done("bp", 200, 1'b0);
    check_beats("bp", 0, 31);
    if (got_edge.size() > 4) begin
      chk("bp_accept3_edge", 32'(got_edge[3]), 32'(a));
      chk("bp_beat4_gap",    32'(got_edge[4] - got_edge[3]), 32'd2);
    end

    // Random register contents with random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      clear_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      run_to_done("rnd", 400, 1'b1);
      check_beats("rnd", 0, 31);
    end

    // Abort in SEND of beat 7 with a simultaneous handshake
    clear_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beat("ab", 7, 50);
    out_ready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 32'd0);
    chk("ab_busy",  32'(busy),      32'd0);
    chk("ab_done",  32'(done),      32'd0);
    tick();
    chk("ab_done_next", 32'(done), 32'd0);
    chk("ab_count", 32'(got_idx.size()), 32'd7);
    chk("ab_last_idx", 32'(got_idx.size() > 0 ? got_idx[got_idx.size() - 1] : -1), 32'd6);
    clear_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ab_restart_valid", 32'(out_valid), 32'd1);
    chk("ab_restart_index", 32'(out_index), 32'd0);
    run_to_done("ab_restart", 200, 1'b0);
    check_beats("ab_restart", 0, 31);

    // Asynchronous reset during FETCH of beat 10
    clear_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beat("rm", 9, 50);
    tick();
    chk("rm_fetch_addr",  32'(rf_addr),   32'd10);
    chk("rm_fetch_valid", 32'(out_valid), 32'd0);
    chk("rm_fetch_busy",  32'(busy),      32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_rf_addr",   32'(rf_addr),   32'd0);
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_out_data",  out_data,       32'd0);
    chk("rm_out_index", 32'(out_index), 32'd0);
    chk("rm_out_last",  32'(out_last),  32'd0);
    chk("rm_busy",      32'(busy),      32'd0);
    chk("rm_done",      32'(done),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    chk("rm_idle_busy",  32'(busy),      32'd0);
    chk("rm_idle_valid", 32'(out_valid), 32'd0);

    // Start pulse mid-dump is ignored
    clear_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beat("sp", 5, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("sp", 200, 1'b0);
    check_beats("sp", 0, 31);

    // Continuously high start: back-to-back dumps
    clear_sb();
    start = 1'b1;
    run_to_done("cont1", 200, 1'b0);
    chk("cont_done_valid", 32'(out_valid), 32'd0);
    tick();
    chk("cont_fetch_busy",  32'(busy),      32'd1);
    chk("cont_fetch_valid", 32'(out_valid), 32'd0);
    tick();
    chk("cont_first_valid", 32'(out_valid), 32'd1);
    chk("cont_first_index", 32'(out_index), 32'd0);
    start = 1'b0;
    check_beats("cont1", 0, 31);
    clear_sb();
    run_to_done("cont2", 200, 1'b0);
    check_beats("cont2", 0, 31);

    // Single-register instance (FIRST_REG = LAST_REG = 5)
    regs[5] = 32'hDEAD_BEEF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("one_busy",  32'(busy1),    32'd1);
    chk("one_addr",  32'(rf_addr1), 32'd5);
    tick();
    chk("one_valid", 32'(out_valid1), 32'd1);
    chk("one_index", 32'(out_index1), 32'd5);
    chk("one_last",  32'(out_last1),  32'd1);
    chk("one_data",  out_data1,       32'hDEAD_BEEF);
    tick();
    chk("one_accept_valid", 32'(out_valid1), 32'd0);
    chk("one_done",         32'(done1),      32'd1);
    tick();
    chk("one_done_pulse", 32'(done1), 32'd0);
    chk("one_idle_busy",  32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the MIPS single-cycle core. It acts as the reader for `RegFile`: it owns one read-address port, walks register indices FIRST_REG..LAST_REG on request, and presents each register value on a valid/ready stream toward the debug/trace interface. The core keeps running during a dump, and each value is sampled at the instant it is captured.

## Interface
- `FIRST_REG`, default 0: first index dumped.
  - Constraint: 0 ≤ FIRST_REG ≤ LAST_REG ≤ 31.
- `LAST_REG`, default 31: last index dumped.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high; all state is cleared immediately.
- `start`  in  1: level; sampled only in IDLE; begins a dump.
- `abort`  in  1: level; sampled in FETCH/SEND; terminates a dump.
- `rf_addr`  out  5: drives the RegFile read address.
- `rf_data`  in  32: combinational read data from RegFile for `rf_addr`.
- `out_valid`  out  1: stream beat valid.
- `out_ready`  in  1: downstream accepts the beat.
- `out_data`  out  32: captured register value.
- `out_index`  out  5: register index of `out_data`.
- `out_last`  out  1: beat is index LAST_REG.
- `busy`  out  1: high in FETCH or SEND.
- `done`  out  1: one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - `rf_addr` = FIRST_REG, `out_valid` = 0.
  - `start`=1 at an edge: go to FETCH with index = FIRST_REG.
  - `abort` is ignored.
- FETCH:
  - `rf_addr` = index, held for the full cycle.
  - At the edge: `out_data` ← `rf_data`, `out_index` ← index, `out_last` ← (index==LAST_REG), `out_valid` ← 1; go to SEND.
- SEND:
  - `out_valid`=1. `out_data`, `out_index`, `out_last` and `rf_addr` are held stable until handshake.
  - Handshake = `out_valid & out_ready` at an edge.
  - On handshake with index≠LAST_REG: index ← index+1, `out_valid` ← 0, go to FETCH.
  - On handshake with index==LAST_REG: `out_valid` ← 0, `done` ← 1 for one cycle, go to IDLE.
- Abort: `abort`=1 at an edge in FETCH or SEND → IDLE, `out_valid` ← 0, no `done`.
  - Abort has priority over a simultaneous handshake; that beat counts as not accepted.
- `start` asserted while busy is ignored.
- `start` high in the IDLE cycle in which `done` is high starts a new dump. A continuously high `start` therefore dumps back-to-back.
- Index is 5-bit and never increments past LAST_REG, so no wrap-around occurs.
- The block never writes RegFile and never drives its write port.

## Timing
- Reset values: state=IDLE, `rf_addr`=FIRST_REG, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` sampled at edge k:
  - FETCH occupies cycle k..k+1.
  - `out_valid` rises after edge k+1.
- Throughput: 2 cycles per beat with `out_ready` tied high. Each stall cycle adds 1.
- Full 32-register dump, ready always high:
  - Beat n is accepted at edge k+2+2n.
  - `done` is high in the cycle after edge k+64.
- `done` and `out_valid` are never high in the same cycle.
- `busy` is high from edge k through the last-handshake edge.
- `reset` asserted mid-dump: outputs go to reset values asynchronously. After release the block is in IDLE and needs a fresh `start`.

## Test plan
- **Full dump:** preload reg i = 0x1000_0000+i for i=1..31 (reg 0 reads 0); pulse `start`; hold `out_ready`=1.
  - Expect 32 beats with `out_index` 0..31 and `out_data` matching.
  - `out_last` set only on index 31.
  - `done` high exactly one cycle, after edge k+64.
- **Backpressure:** drop `out_ready` for 5 cycles while beat 3 is valid.
  - `out_data`=0x1000_0003, `out_index`=3 and `rf_addr`=3 stay stable throughout.
  - Beat 4 follows 2 cycles after acceptance.
- **Abort:** assert `abort` in SEND of beat 7 with `out_ready`=1 on the same edge.
  - Next cycle: `out_valid`=0, `busy`=0, no `done`, beat 7 not counted.
  - A subsequent `start` restarts at index 0.
- **Reset mid-dump:** assert `reset` asynchronously during FETCH of beat 10.
  - All outputs reach reset values before the next edge.
  - After release the block stays IDLE until `start`.
- **Start handling:** pulse `start` during beat 5 → ignored, dump continues unchanged. Hold `start` high continuously → second dump begins in the `done` cycle, and its first beat (index 0) is valid 2 cycles later.
- **Single-register parameterisation:** FIRST_REG=LAST_REG=5, reg 5 = 0xDEAD_BEEF → one beat with `out_index`=5, `out_last`=1, `out_data`=0xDEAD_BEEF, then `done`.
